// File: rtl/adc_apb_fifo_wrapper_pkg.sv
// Shared constants for the APB-mapped dummy ADC sample FIFO.
// Register addresses, status layout and sample format.
package adc_apb_fifo_wrapper_pkg;

  localparam int STATUS_REG_ADDR     = 'h000;
  localparam int ADC_TRIGGER_ADDR    = 'h004;
  localparam int MEASUREMENT_HI_ADDR = 'h008;
  localparam int MEASUREMENT_LO_ADDR = 'h00C;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam int FIFO_DEPTH = 8;
  localparam int SAMPLE_W   = 56;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;
  localparam int SEQ_W      = 16;

  localparam logic [15:0] ADC_TAG = 16'hADC0;

  function automatic logic [SAMPLE_W-1:0] make_sample(
    input logic [SEQ_W-1:0] seq
  );
    return {ADC_TAG, seq, 8'h00, seq};
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous 8-deep sample FIFO with first-word fall-through head.
// Push into a full FIFO is dropped unless a pop frees a slot that edge.
module adc_sample_fifo
  import adc_apb_fifo_wrapper_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates validity.
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at 8; count tracks occupancy 0..8.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_apb_fifo_wrapper.sv
// APB slave exposing a dummy ADC whose samples queue in a FIFO.
// Trigger writes sample one edge later; LO reads pop the head.
module adc_apb_fifo_wrapper
  import adc_apb_fifo_wrapper_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  logic                  is_stat;
  logic                  is_trig;
  logic                  is_hi;
  logic                  is_lo;
  logic                  access;
  logic                  err;
  logic                  ok;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] status;

  logic                  pend;
  logic [SEQ_W-1:0]      seq;
  logic                  ovf;
  logic                  trig_fire;
  logic                  pop;
  logic                  stat_rd;

  logic [SAMPLE_W-1:0]   head;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  assign is_stat = (PADDR == ADDR_WIDTH'(STATUS_REG_ADDR));
  assign is_trig = (PADDR == ADDR_WIDTH'(ADC_TRIGGER_ADDR));
  assign is_hi   = (PADDR == ADDR_WIDTH'(MEASUREMENT_HI_ADDR));
  assign is_lo   = (PADDR == ADDR_WIDTH'(MEASUREMENT_LO_ADDR));
  assign access  = PSEL & PENABLE;
  assign ok      = access & ~err;

  assign trig_fire = ok & is_trig & PWRITE & PWDATA[0];
  assign pop       = ok & is_lo & ~PWRITE;
  assign stat_rd   = ok & is_stat & ~PWRITE;

  assign PREADY  = 1'b1;
  assign PSLVERR = access & err;
  assign PRDATA  = (PSEL & ~PWRITE) ? rd_mux : '0;

  // Status word assembled from FIFO flags and the sticky overflow.
  always_comb begin
    status = '0;
    status[ST_NOT_EMPTY]          = ~empty;
    status[ST_FULL]               = full;
    status[ST_OVERFLOW]           = ovf;
    status[ST_COUNT_LSB +: CNT_W] = count;
  end

  // Address decode: read mux and error classification.
  always_comb begin
    rd_mux = '0;
    err    = 1'b1;
    unique case (1'b1)
      is_stat: begin
        err    = PWRITE;
        rd_mux = status;
      end
      is_trig: begin
        err = ~PWRITE;
      end
      is_hi: begin
        err = PWRITE | empty;
        if (!empty) rd_mux = DATA_WIDTH'(head[55:24]);
      end
      is_lo: begin
        err = PWRITE | empty;
        if (!empty) rd_mux = DATA_WIDTH'({8'h00, head[23:0]});
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  // Dummy ADC: a pending trigger samples and advances seq next edge.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      pend <= 1'b0;
      seq  <= SEQ_W'(1);
    end else begin
      pend <= trig_fire;
      if (pend) seq <= seq + 1'b1;
    end
  end

  // Sticky overflow: set on a dropped sample, cleared by a STATUS read.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      ovf <= 1'b0;
    end else if (pend && full && !pop) begin
      ovf <= 1'b1;
    end else if (stat_rd) begin
      ovf <= 1'b0;
    end
  end

  adc_sample_fifo u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (pend),
    .pop     (pop),
    .wdata   (make_sample(seq)),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_adc_apb_fifo_wrapper.sv
// Directed bench for adc_apb_fifo_wrapper.
// Single-cycle APB accesses driven on the falling edge.
module tb_adc_apb_fifo_wrapper;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic [11:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks;
  int failures;

  adc_apb_fifo_wrapper dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PADDR   (PADDR),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d,
                        output logic e);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] v,
                        output logic e);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = v;
    #1;
    e = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    checks = 0;
    failures = 0;
    PRESETn = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (2) @(negedge PCLK);
    check("rst_pready", PREADY, 1);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_prdata", PRDATA, 0);
    PRESETn = 1'b0;

    apb_rd(12'h000, d, e);
    check("stat0", d, 32'h0);
    check("stat0_err", e, 0);

    apb_wr(12'h004, 32'h1, e);
    check("trig_err", e, 0);
    idle();
    apb_rd(12'h000, d, e);
    check("stat1", d, 32'h11);
    apb_rd(12'h008, d, e);
    check("hi1", d, 32'hADC00001);
    apb_rd(12'h00C, d, e);
    check("lo1", d, 32'h1);
    check("lo1_err", e, 0);
    apb_rd(12'h000, d, e);
    check("stat_empty", d[1:0], 2'b00);

    apb_wr(12'h004, 32'h2, e);
    idle();
    apb_rd(12'h000, d, e);
    check("trig_bit0_clr", d, 32'h0);

    do_reset();
    for (int i = 0; i < 9; i++) apb_wr(12'h004, 32'h1, e);
    idle();
    apb_rd(12'h000, d, e);
    check("stat_full_ovf", d, 32'h87);
    apb_rd(12'h000, d, e);
    check("stat_ovf_clr", d, 32'h83);
    for (int k = 1; k <= 8; k++) begin
      apb_rd(12'h008, d, e);
      check($sformatf("hi_seq%0d", k), d, 32'hADC00000 | k);
      apb_rd(12'h00C, d, e);
      check($sformatf("lo_seq%0d", k), d, k);
    end
    apb_rd(12'h000, d, e);
    check("stat_drained", d, 32'h0);

    apb_rd(12'h00C, d, e);
    check("lo_empty_data", d, 32'h0);
    check("lo_empty_err", e, 1);
    apb_rd(12'h008, d, e);
    check("hi_empty_err", e, 1);
    apb_rd(12'h000, d, e);
    check("count_still0", d, 32'h0);
    apb_rd(12'h010, d, e);
    check("unmapped_err", e, 1);
    apb_rd(12'h004, d, e);
    check("trig_rd_err", e, 1);
    apb_wr(12'h000, 32'h1, e);
    check("stat_wr_err", e, 1);
    apb_wr(12'h00C, 32'h1, e);
    check("lo_wr_err", e, 1);
    idle();
    check("err_phase_only", PSLVERR, 0);

    apb_wr(12'h004, 32'h1, e);
    idle();
    apb_wr(12'h004, 32'h1, e);
    apb_rd(12'h00C, d, e);
    check("same_edge_lo", d, 32'h0000000A);
    apb_rd(12'h000, d, e);
    check("same_edge_stat", d, 32'h11);
    apb_rd(12'h008, d, e);
    check("same_edge_hi", d, 32'hADC0000B);
    apb_rd(12'h00C, d, e);
    check("same_edge_lo2", d, 32'h0000000B);

    apb_wr(12'h004, 32'h1, e);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    check("mid_rst_prdata", PRDATA, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    apb_rd(12'h000, d, e);
    check("mid_rst_stat", d, 32'h0);
    apb_wr(12'h004, 32'h1, e);
    idle();
    apb_rd(12'h008, d, e);
    check("mid_rst_hi", d, 32'hADC00001);
    apb_rd(12'h00C, d, e);
    check("mid_rst_lo", d, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_apb_fifo_wrapper.md
ADC_APB_FIFO_WRAPPER -- requirements
Module: adc_apb_fifo_wrapper

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports are named PCLK and PRESETn as in the codebase, with PRESETn asserted when 1.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning APB address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning APB data width.
REQ-004 The block SHALL have port PCLK  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port PRESETn  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port PSEL  input  1  slave select.
REQ-007 The block SHALL have port PADDR  input  ADDR_WIDTH  byte address.
REQ-008 The block SHALL have port PENABLE  input  1  access phase.
REQ-009 The block SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-010 The block SHALL have port PWDATA  input  DATA_WIDTH  write data.
REQ-011 The block SHALL have port PRDATA  output  DATA_WIDTH  read data.
REQ-012 The block SHALL have port PREADY  output  1  tied 1, no wait states.
REQ-013 The block SHALL have port PSLVERR  output  1  error response.

Function
REQ-014 A transfer SHALL complete on any rising edge with PSEL=1 and PENABLE=1; no separate setup cycle is required.
REQ-015 Register map SHALL be: STATUS_REG_ADDR 0x000 (RO); ADC_TRIGGER_ADDR 0x004 (WO); MEASUREMENT_HI_ADDR 0x008 (RO); MEASUREMENT_LO_ADDR 0x00C (RO).
REQ-016 PRDATA SHALL be the combinational read mux when PSEL=1 and PWRITE=0, and 0 otherwise.
REQ-017 status_reg[31:0] SHALL be: bit0 not_empty; bit1 full; bit2 overflow (sticky); bits[7:4] FIFO count 0..8; all other bits 0. FIFO empty gives [1:0]=00.
REQ-018 A write to ADC_TRIGGER with PWDATA[0]=1 SHALL make the dummy ADC produce one 56-bit sample on the next edge, and the sample SHALL be pushed into the FIFO on that edge. Writes with PWDATA[0]=0 SHALL have no effect.
REQ-019 Dummy ADC sample SHALL come from a 16-bit sequence counter seq, starting at 1 after reset and incrementing per trigger. Sample = {16'hADC0, seq} (upper 32 bits) concatenated with {8'h00, seq} (lower 24 bits).
REQ-020 The FIFO SHALL have depth 8 and width 56 bits.
REQ-021 A read of MEASUREMENT_HI SHALL return the head sample bits[55:24] without popping.
REQ-022 A read of MEASUREMENT_LO SHALL return {8'h00, head bits[23:0]} and pop the head on completion.
REQ-023 A MEASUREMENT read while the FIFO is empty SHALL return 0, assert PSLVERR and not pop.
REQ-024 A trigger while the FIFO is full SHALL discard the sample and set overflow; seq SHALL still increment.
REQ-025 Overflow SHALL clear on completion of a STATUS read.
REQ-026 If a push and a pop occur on the same edge, both SHALL occur and the count SHALL stay unchanged.
REQ-027 FIFO pointers SHALL wrap modulo 8.
REQ-028 PSLVERR SHALL be 1, during the access phase only, for unmapped addresses, reads of ADC_TRIGGER, writes to RO registers, and empty MEASUREMENT reads. Error accesses SHALL have no side effects.

Reset
REQ-029 While PRESETn=1, the block SHALL hold: FIFO pointers and count 0, overflow 0, seq 1, pending trigger cleared, PRDATA 0, PSLVERR 0, PREADY 1.
REQ-030 Reset asserted mid-operation SHALL abort any pending trigger and leave the FIFO empty.

Structure
REQ-031 A shared package SHALL hold: the four address constants, status bit positions, FIFO_DEPTH=8, SAMPLE_W=56, and ADC tag 16'hADC0.
REQ-032 The synchronous FIFO SHALL be one sub-module, adc_sample_fifo, with push/pop/full/empty/count.
REQ-033 APB decode and the dummy ADC SHALL be inline in adc_apb_fifo_wrapper.

Verification
REQ-034 Reset, then read STATUS -> PRDATA=0x00000000, PSLVERR=0.
REQ-035 Write 0x1 to 0x004, wait 1 cycle, read STATUS -> 0x00000011; read 0x008 -> 0xADC00001; read 0x00C -> 0x00000001; then read STATUS -> [1:0]=00.
REQ-036 Issue 9 triggers -> STATUS=0x00000087. Read STATUS again -> 0x00000083. The 8 HI/LO pairs pop seq 1..8 in order; seq 9 is lost.
REQ-037 Read 0x00C with FIFO empty -> PRDATA=0, PSLVERR=1, count remains 0. Access to 0x010 -> PSLVERR=1.
REQ-038 With 1 entry held, trigger and LO read on the same edge -> count stays 1 and the new head is the next seq.
REQ-039 Assert PRESETn one cycle after a trigger -> after release, STATUS=0 and the next sample has seq=1.
